// File: rtl/tour_pdt_pkg.sv
// Shared definitions for the tournament branch predictor: FSM encoding,
// 2-bit counter constants and the saturating-update helper.
package tour_pdt_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = 2'b01;
  localparam logic [CNT_W-1:0] CHO_INIT = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX  = 2'b11;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_INIT = 2'd3
  } cnt_op_t;

  // Saturating step: stays at 0 when counting down and at CNT_MAX when up.
  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                  input logic up);
    if (up) return (cnt == CNT_MAX) ? cnt : cnt + 2'd1;
    else    return (cnt == '0)      ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/tour_pdt_sat_cnt_table.sv
// Table of 2-bit saturating counters: one combinational read port and one
// write port performing increment, decrement or initialisation.
module sat_cnt_table
  import tour_pdt_pkg::*;
#(
  parameter int               DEPTH_W  = 10,
  parameter logic [CNT_W-1:0] INIT_VAL = CNT_INIT
) (
  input  logic               clk,
  input  logic [DEPTH_W-1:0] rd_idx,
  output logic [CNT_W-1:0]   rd_cnt,
  input  logic [DEPTH_W-1:0] wr_idx,
  input  cnt_op_t            op
);

  logic [CNT_W-1:0] mem [2**DEPTH_W];

  // NOTE: the array has no reset; the INIT sweep writes every entry before use.
  always_ff @(posedge clk) begin
    case (op)
      OP_INC:  mem[wr_idx] <= sat_update(mem[wr_idx], 1'b1);
      OP_DEC:  mem[wr_idx] <= sat_update(mem[wr_idx], 1'b0);
      OP_INIT: mem[wr_idx] <= INIT_VAL;
      default: ;
    endcase
  end

  assign rd_cnt = mem[rd_idx];

endmodule

// File: rtl/tour_pdt.sv
// Tournament branch predictor: bimodal + gshare components, a chooser table,
// a direct-mapped BTB and a speculative global history with recovery.
module tour_pdt
  import tour_pdt_pkg::*;
#(
  parameter int GHR_W = 10,
  parameter int IDX_W = 10,
  parameter int BTB_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic             if_valid,
  input  logic             if_stall,
  output logic             pdt_taken,
  output logic [31:0]      pdt_target,
  output logic             pdt_which,
  output logic [1:0]       pdt_comp,
  output logic [GHR_W-1:0] pdt_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  input  logic [1:0]       upd_comp,
  input  logic [GHR_W-1:0] upd_ghr,
  output logic             ready
);

  localparam int SWP_W = (IDX_W > BTB_W) ? IDX_W : BTB_W;
  localparam int TAG_W = 32 - BTB_W - 2;

  state_t             state, state_nxt;
  logic [SWP_W-1:0]   swp_idx;
  logic [GHR_W-1:0]   ghr;
  logic               run;

  logic [IDX_W-1:0]   bm_idx, gs_idx, upd_bm_idx, upd_gs_idx;
  logic [BTB_W-1:0]   btb_idx, upd_btb_idx;
  logic [TAG_W-1:0]   if_tag;
  logic [CNT_W-1:0]   bm_cnt, gs_cnt, ch_cnt;
  logic               btb_hit;

  logic [IDX_W-1:0]   tbl_wr_idx, gs_wr_idx;
  cnt_op_t            bm_op, gs_op, ch_op;

  logic               btb_valid  [2**BTB_W];
  logic [TAG_W-1:0]   btb_tag    [2**BTB_W];
  logic [31:0]        btb_target [2**BTB_W];

  logic unused;
  assign unused = ^{if_pc[1:0], upd_pc[1:0]};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_INIT;
      swp_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) swp_idx <= swp_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && swp_idx == {SWP_W{1'b1}}) state_nxt = ST_RUN;
  end

  // Index generation for both the fetch and the update side.
  assign bm_idx      = if_pc[IDX_W+1:2];
  assign gs_idx      = bm_idx ^ IDX_W'(ghr);
  assign btb_idx     = if_pc[BTB_W+1:2];
  assign if_tag      = if_pc[31:BTB_W+2];
  assign upd_bm_idx  = upd_pc[IDX_W+1:2];
  assign upd_gs_idx  = upd_bm_idx ^ IDX_W'(upd_ghr);
  assign upd_btb_idx = upd_pc[BTB_W+1:2];
  assign btb_hit     = btb_valid[btb_idx] && (btb_tag[btb_idx] == if_tag);

  // Output process.
  always_comb begin
    run        = (state == ST_RUN);
    ready      = run;
    pdt_which  = ch_cnt[CNT_W-1];
    pdt_comp   = {gs_cnt[CNT_W-1], bm_cnt[CNT_W-1]};
    pdt_target = btb_target[btb_idx];
    pdt_ghr    = ghr;
    pdt_taken  = run && btb_hit && (pdt_which ? gs_cnt[CNT_W-1] : bm_cnt[CNT_W-1]);
  end

  // Table write control: INIT sweep wins; updates only act in RUN.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    bm_op      = OP_NONE;
    gs_op      = OP_NONE;
    ch_op      = OP_NONE;
    tbl_wr_idx = upd_bm_idx;
    gs_wr_idx  = upd_gs_idx;
    if (!run) begin
      bm_op      = OP_INIT;
      gs_op      = OP_INIT;
      ch_op      = OP_INIT;
      tbl_wr_idx = swp_idx[IDX_W-1:0];
      gs_wr_idx  = swp_idx[IDX_W-1:0];
    end else if (upd_valid) begin
      bm_op = upd_taken ? OP_INC : OP_DEC;
      gs_op = upd_taken ? OP_INC : OP_DEC;
      if (upd_comp[1] != upd_comp[0])
        ch_op = (upd_comp[1] == upd_taken) ? OP_INC : OP_DEC;
    end
  end

  sat_cnt_table #(.DEPTH_W(IDX_W), .INIT_VAL(CNT_INIT)) u_bimodal (
    .clk(clk), .rd_idx(bm_idx), .rd_cnt(bm_cnt), .wr_idx(tbl_wr_idx), .op(bm_op)
  );

  sat_cnt_table #(.DEPTH_W(IDX_W), .INIT_VAL(CNT_INIT)) u_gshare (
    .clk(clk), .rd_idx(gs_idx), .rd_cnt(gs_cnt), .wr_idx(gs_wr_idx), .op(gs_op)
  );

  sat_cnt_table #(.DEPTH_W(IDX_W), .INIT_VAL(CHO_INIT)) u_chooser (
    .clk(clk), .rd_idx(bm_idx), .rd_cnt(ch_cnt), .wr_idx(tbl_wr_idx), .op(ch_op)
  );

  always_ff @(posedge clk) begin
    if (!run) begin
      btb_valid[swp_idx[BTB_W-1:0]] <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      btb_valid[upd_btb_idx]  <= 1'b1;
      btb_tag[upd_btb_idx]    <= upd_pc[31:BTB_W+2];
      btb_target[upd_btb_idx] <= upd_target;
    end
  end

  // Speculative history; a mispredict recovery overrides the fetch-side shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (run) begin
      if (upd_valid && upd_mispredict)
        ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
      else if (if_valid && !if_stall && btb_hit)
        ghr <= {ghr[GHR_W-2:0], pdt_taken};
    end
  end

endmodule

// File: tb/tb_tour_pdt.sv
// Randomised and directed bench for tour_pdt against a table-level model.
module tb_tour_pdt;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_valid, if_stall;
  logic        pdt_taken, pdt_which;
  logic [31:0] pdt_target;
  logic [1:0]  pdt_comp;
  logic [9:0]  pdt_ghr;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_comp;
  logic [9:0]  upd_ghr;
  logic        ready;

  tour_pdt dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_valid(if_valid), .if_stall(if_stall),
    .pdt_taken(pdt_taken), .pdt_target(pdt_target), .pdt_which(pdt_which),
    .pdt_comp(pdt_comp), .pdt_ghr(pdt_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .upd_comp(upd_comp), .upd_ghr(upd_ghr), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: plain integer tables.
  int          m_bm [1024];
  int          m_gs [1024];
  int          m_ch [1024];
  bit          m_bv [64];
  int unsigned m_tag[64];
  int unsigned m_tgt[64];
  int unsigned m_ghr;

  // Expected values from the last step and DUT values seen there.
  bit          exp_taken;
  logic [1:0]  exp_comp;
  logic [9:0]  exp_ghr;
  logic        obs_taken, obs_which;
  logic [31:0] obs_target;
  logic [1:0]  obs_comp;
  logic [9:0]  obs_ghr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 3) ? 3 : v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      m_bm[i] = 1; m_gs[i] = 1; m_ch[i] = 1;
    end
    for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
    m_ghr = 0;
  endtask

  task automatic idle_inputs();
    if_pc = 32'h0; if_valid = 1'b0; if_stall = 1'b0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_mispredict = 1'b0; upd_comp = 2'b00; upd_ghr = 10'h0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic mis, input logic [1:0] comp, input logic [9:0] gh);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_mispredict = mis; upd_comp = comp; upd_ghr = gh;
  endtask

  // Inputs are already driven; compare at negedge, advance model, return at posedge+1.
  task automatic step();
    int unsigned pc, bmi, gsi, bti, ubm, ugs, ubt, nghr;
    bit hit, e_which, gs_msb, bm_msb;
    @(negedge clk);
    pc     = if_pc;
    bmi    = (pc >> 2) & 1023;
    gsi    = bmi ^ m_ghr;
    bti    = (pc >> 2) & 63;
    hit    = m_bv[bti] && (m_tag[bti] == (pc >> 8));
    e_which = (m_ch[bmi] >= 2);
    gs_msb = (m_gs[gsi] >= 2);
    bm_msb = (m_bm[bmi] >= 2);
    exp_taken = hit && (e_which ? gs_msb : bm_msb);
    exp_comp  = {gs_msb, bm_msb};
    exp_ghr   = 10'(m_ghr);
    obs_taken = pdt_taken; obs_which = pdt_which; obs_target = pdt_target;
    obs_comp  = pdt_comp;  obs_ghr   = pdt_ghr;
    check("ready", 32'(ready), 32'd1);
    check("taken", 32'(pdt_taken), 32'(exp_taken));
    check("which", 32'(pdt_which), 32'(e_which));
    check("comp",  32'(pdt_comp),  32'(exp_comp));
    check("ghr",   32'(pdt_ghr),   m_ghr);
    if (hit) check("target", pdt_target, m_tgt[bti]);

    nghr = m_ghr;
    if (upd_valid && upd_mispredict)
      nghr = ((32'(upd_ghr) << 1) | 32'(upd_taken)) & 1023;
    else if (if_valid && !if_stall && hit)
      nghr = ((m_ghr << 1) | 32'(exp_taken)) & 1023;
    if (upd_valid) begin
      ubm = (upd_pc >> 2) & 1023;
      ugs = ubm ^ 32'(upd_ghr);
      ubt = (upd_pc >> 2) & 63;
      m_bm[ubm] = sat(m_bm[ubm] + (upd_taken ? 1 : -1));
      m_gs[ugs] = sat(m_gs[ugs] + (upd_taken ? 1 : -1));
      if (upd_comp[1] != upd_comp[0])
        m_ch[ubm] = sat(m_ch[ubm] + ((upd_comp[1] == upd_taken) ? 1 : -1));
      if (upd_taken) begin
        m_bv[ubt] = 1'b1; m_tag[ubt] = upd_pc >> 8; m_tgt[ubt] = upd_target;
      end
    end
    m_ghr = nghr;
    @(posedge clk); #1;
  endtask

  // Releases reset and measures the INIT sweep, leaving us at posedge+1.
  task automatic release_and_sweep(input string tag);
    int cyc;
    bit taken_seen;
    cyc = 0; taken_seen = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 2000 && !ready; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (!ready && pdt_taken) taken_seen = 1'b1;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'd1024);
    check({tag, "_taken_in_init"}, 32'(taken_seen), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int correct;
    bit t;
    int unsigned pc_pool[6];

    // Reset with update and fetch activity present; everything must be ignored.
    idle_inputs();
    rst = 1'b0;
    if_pc = 32'h100; if_valid = 1'b1;
    set_upd(32'h100, 1'b1, 32'h200, 1'b1, 2'b01, 10'h3FF);
    #12;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_taken", 32'(pdt_taken), 32'd0);
    check("rst_ghr", 32'(pdt_ghr), 32'd0);
    release_and_sweep("init");
    idle_inputs();
    if_pc = 32'h100; if_valid = 1'b1;
    step();
    check("init_upd_ignored", 32'(obs_taken), 32'd0);

    // Four taken updates train 0x100 fully.
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      set_upd(32'h100, 1'b1, 32'h200, 1'b0, 2'b00, 10'h0);
      step();
    end
    idle_inputs();
    if_pc = 32'h100; if_valid = 1'b1;
    step();
    check("train_taken", 32'(obs_taken), 32'd1);
    check("train_target", obs_target, 32'h200);
    check("train_comp", 32'(obs_comp), 32'd3);

    // Saturation at both ends on bimodal entry of 0x380.
    idle_inputs();
    for (int i = 0; i < 5; i++) begin set_upd(32'h380, 1'b1, 32'h900, 1'b0, 2'b00, 10'h0); step(); end
    set_upd(32'h380, 1'b0, 32'h900, 1'b0, 2'b00, 10'h0); step();
    idle_inputs(); if_pc = 32'h380; step();
    check("sat_hi_bm", 32'(obs_comp[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin set_upd(32'h380, 1'b0, 32'h900, 1'b0, 2'b00, 10'h0); step(); end
    set_upd(32'h380, 1'b1, 32'h900, 1'b0, 2'b00, 10'h0); step();
    idle_inputs(); if_pc = 32'h380; step();
    check("sat_lo_bm", 32'(obs_comp[0]), 32'd0);

    // Alternating branch at 0x40 with comp/ghr feedback from the prediction.
    correct = 0;
    for (int i = 0; i < 20; i++) begin
      t = (i % 2 == 0);
      idle_inputs(); if_pc = 32'h40; if_valid = 1'b1;
      step();
      if (i >= 14 && exp_taken == t) correct++;
      idle_inputs();
      set_upd(32'h40, t, 32'h80, exp_taken != t, exp_comp, exp_ghr);
      step();
    end
    idle_inputs(); if_pc = 32'h40; if_valid = 1'b1;
    step();
    check("alt_which", 32'(obs_which), 32'd1);
    check("alt_next_taken", 32'(obs_taken), 32'd1);
    check("alt_tracking", 32'(correct), 32'd6);

    // Recovery beats a same-cycle speculative shift.
    idle_inputs();
    set_upd(32'h7F0, 1'b1, 32'h444, 1'b1, 2'b00, 10'h1FF);
    step();
    idle_inputs(); if_pc = 32'h100; if_valid = 1'b1;
    set_upd(32'h7F0, 1'b0, 32'h444, 1'b1, 2'b00, 10'h155);
    step();
    check("rec_pre_ghr", 32'(obs_ghr), 32'h3FF);
    idle_inputs();
    step();
    check("rec_ghr", 32'(obs_ghr), 32'h2AA);

    // Random mix of fetches and updates.
    pc_pool[0] = 32'h100; pc_pool[1] = 32'h40; pc_pool[2] = 32'h380;
    pc_pool[3] = 32'h7F0; pc_pool[4] = 32'h1100;
    for (int i = 0; i < 400; i++) begin
      pc_pool[5] = $urandom & 32'hFFFF_FFFC;
      if_pc    = pc_pool[$urandom_range(0, 5)];
      if_valid = 1'($urandom);
      if_stall = ($urandom_range(0, 3) == 0);
      upd_valid = 1'($urandom);
      upd_pc   = pc_pool[$urandom_range(0, 5)];
      upd_taken = 1'($urandom);
      upd_target = $urandom;
      upd_mispredict = ($urandom_range(0, 3) == 0);
      upd_comp = 2'($urandom);
      upd_ghr  = 10'($urandom);
      step();
    end

    // Reset mid-RUN after retraining 0x100.
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      set_upd(32'h100, 1'b1, 32'h200, 1'b0, 2'b01, 10'h0);
      step();
    end
    idle_inputs(); if_pc = 32'h100; if_valid = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_taken", 32'(pdt_taken), 32'd0);
    check("mid_rst_ghr", 32'(pdt_ghr), 32'd0);
    release_and_sweep("resweep");
    if_pc = 32'h100; if_valid = 1'b1;
    step();
    check("resweep_taken", 32'(obs_taken), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tour_pdt.md
TOUR_PDT -- requirements
Module: tour_pdt

Interface
REQ-001 Parameter GHR_W, default 10, global history length in bits (range 2..IDX_W).
REQ-002 Parameter IDX_W, default 10, index width of bimodal PHT, gshare PHT and chooser (2^IDX_W entries each).
REQ-003 Parameter BTB_W, default 6, BTB index width (2^BTB_W entries, tag = pc[31:BTB_W+2]).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 if_pc  input  32  fetch-stage PC; if_valid  input  1  fetch slot valid; if_stall  input  1  fetch frozen.
REQ-007 pdt_taken  output  1; pdt_target  output  32; pdt_which  output  1 (1 = gshare chosen); pdt_comp  output  2 ({gshare MSB, bimodal MSB}); pdt_ghr  output  GHR_W.
REQ-008 upd_valid  input  1; upd_pc  input  32; upd_taken  input  1; upd_target  input  32; upd_mispredict  input  1; upd_comp  input  2; upd_ghr  input  GHR_W.
REQ-009 ready  output  1  high when table initialisation is complete.

Function
REQ-010 FSM states INIT and RUN; INIT entered on reset, sweeps index counter 0..2^max(IDX_W,BTB_W)-1, one entry per cycle, then RUN; no exit from RUN except reset.
REQ-011 INIT writes bimodal/gshare counters to 2'b01, chooser to 2'b01, BTB valid to 0; ready=0, pdt_taken=0 throughout INIT.
REQ-012 Prediction combinational, zero latency: bm_idx = if_pc[IDX_W+1:2]; gs_idx = bm_idx XOR zero-extended GHR; btb_idx = if_pc[BTB_W+1:2].
REQ-013 pdt_which = chooser[bm_idx] MSB; pdt_comp = {gshare[gs_idx] MSB, bimodal[bm_idx] MSB}; pdt_target = BTB target; pdt_taken = RUN && BTB hit (valid and tag match) && selected component MSB.
REQ-014 pdt_ghr = current speculative GHR, sampled by fetch alongside the prediction.
REQ-015 Speculative GHR: in RUN, if if_valid && !if_stall && BTB hit, GHR <= {GHR[GHR_W-2:0], pdt_taken}; otherwise hold.
REQ-016 Recovery: upd_valid && upd_mispredict sets GHR <= {upd_ghr[GHR_W-2:0], upd_taken}, overriding a same-cycle speculative shift.
REQ-017 On upd_valid in RUN: bimodal[upd_pc idx] and gshare[upd idx XOR upd_ghr] saturate up on upd_taken, down otherwise; range 0..3, no wrap.
REQ-018 Chooser updates only when upd_comp bits differ: increment if upd_comp[1]==upd_taken, decrement if upd_comp[0]==upd_taken; saturating 0..3.
REQ-019 BTB: upd_valid && upd_taken writes valid=1, tag, upd_target at btb index; not-taken updates leave BTB unchanged.
REQ-020 Same-cycle update and prediction on one entry: prediction uses pre-update value; write visible next cycle.
REQ-021 upd_valid during INIT ignored entirely (tables and GHR).

Reset
REQ-022 rst low: FSM=INIT, index counter=0, GHR=0, ready=0, pdt_taken=0 immediately, regardless of clock.
REQ-023 Reset asserted mid-INIT or mid-RUN restarts the full sweep; table contents are not relied on until ready=1.

Structure
REQ-024 Shared package holds FSM state encoding, counter width (2), counter/chooser init values, and saturating-update helper.
REQ-025 One sub-module natural: sat_cnt_table (parametrised depth, 2-bit entries, one combinational read port, one write port with inc/dec/init), instantiated three times.

Verification
REQ-026 Release reset -> ready=0 for exactly 1024 cycles (defaults), then 1; pdt_taken=0 throughout.
REQ-027 Four updates pc=0x100, taken, target=0x200 -> if_pc=0x100 gives pdt_taken=1, pdt_target=0x200, pdt_comp=2'b11.
REQ-028 Alternating T/N branch at 0x40, 20 updates with correct comp feedback -> chooser reaches 3, pdt_which=1, predictions track pattern.
REQ-029 GHR=0x3FF, mispredict update upd_ghr=0x155, upd_taken=0 with simultaneous speculative hit -> next GHR=0x2AA.
REQ-030 Five taken updates on one entry -> counter holds 3; five not-taken -> holds 0, no wrap.
REQ-031 Pull rst low mid-RUN after training -> ready=0 at once, re-sweep, trained entry predicts not-taken afterwards.
